// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t      : loader FSM states
//   DEF_ADDR_W   : default RAM address width
//   DEF_DATA_W   : default bus/data width
//   FULL_LEN     : byte count used when load_len is 0 (whole RAM)
package loader_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned FULL_LEN   = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_BND,
      WAIT_BYTE,
      ADDR,
      DATA,
      RST_CPU,
      DONE
   } state_t;

endpackage

// File: rtl/prog_loader_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
//   clk      : clock, rising edge
//   clr      : asynchronous active-low reset (count cleared)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one when non-zero
//   zero     : count is zero
module down_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/prog_loader.sv
// Host-driven program loader and bus-ownership controller for the SAP CPU.
// Halts the CPU at an instruction boundary, writes host bytes into RAM via
// the shared bus (mi then ri per byte), then pulses cpu_rst and releases.
//   clk, clr        : clock / asynchronous active-low reset
//   start           : load request (IDLE only); latches start_addr, load_len
//   abort           : cancel, honoured in WAIT_BND / WAIT_BYTE only
//   in_data/valid   : host byte stream, in_ready accepts
//   cpu_step_zero   : CPU at instruction boundary
//   cpu_hold        : halts the CPU clock
//   cpu_rst         : CPU reset pulse, RST_CYCLES long
//   bus_o, bus_oe   : shared bus drive
//   mi, ri          : MAR load / RAM write strobes
//   busy, done, aborted : status
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   load_len,
   input  logic              abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              cpu_step_zero,
   output logic              cpu_hold,
   output logic              cpu_rst,
   output logic [DATA_W-1:0] bus_o,
   output logic              bus_oe,
   output logic              mi,
   output logic              ri,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   data_q;
   logic                aborted_q;
   logic [ADDR_W:0]     cnt_init;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic                rst_load, rst_dec, rst_zero;
   logic                take_byte, take_abort;

   // The byte counter holds "bytes remaining after the current one", so the
   // zero flag during DATA marks the last write (same as new cnt == 0).
   assign cnt_init = (load_len == '0) ? (ADDR_W+1)'(FULL_LEN - 1)
                                      : load_len - (ADDR_W+1)'(1);

   assign take_byte  = (state == WAIT_BYTE) && in_valid && !abort;
   assign take_abort = ((state == WAIT_BND) || (state == WAIT_BYTE)) && abort;

   assign cnt_load = (state == IDLE) && start;
   assign cnt_dec  = (state == DATA);
   // Loaded with RST_CYCLES-1 and counted down to zero inside RST_CPU,
   // giving exactly RST_CYCLES cycles of cpu_rst.
   assign rst_load = (state == DATA) && cnt_zero;
   assign rst_dec  = (state == RST_CPU);

   down_counter #(.W(ADDR_W + 1)) u_byte_cnt (
      .clk      (clk),
      .clr      (clr),
      .load     (cnt_load),
      .load_val (cnt_init),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   down_counter #(.W(4)) u_rst_cnt (
      .clk      (clk),
      .clr      (clr),
      .load     (rst_load),
      .load_val (4'(RST_CYCLES - 1)),
      .dec      (rst_dec),
      .zero     (rst_zero)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         addr      <= '0;
         data_q    <= '0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         aborted_q <= take_abort;
         if ((state == IDLE) && start) begin
            addr <= start_addr;
         end else if (state == DATA) begin
            addr <= addr + ADDR_W'(1);
         end
         if (take_byte) begin
            data_q <= in_data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (start) state_nxt = WAIT_BND;
         WAIT_BND: begin
            if (abort)              state_nxt = IDLE;
            else if (cpu_step_zero) state_nxt = WAIT_BYTE;
         end
         WAIT_BYTE: begin
            if (abort)         state_nxt = IDLE;
            else if (in_valid) state_nxt = ADDR;
         end
         ADDR:      state_nxt = DATA;
         DATA:      state_nxt = cnt_zero ? RST_CPU : WAIT_BYTE;
         RST_CPU:   if (rst_zero) state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      cpu_hold = 1'b0;
      cpu_rst  = 1'b0;
      bus_o    = '0;
      bus_oe   = 1'b0;
      mi       = 1'b0;
      ri       = 1'b0;
      done     = 1'b0;
      busy     = (state != IDLE);
      aborted  = aborted_q;
      unique case (state)
         IDLE, WAIT_BND: ;
         WAIT_BYTE: begin
            cpu_hold = 1'b1;
            in_ready = !abort;
         end
         ADDR: begin
            cpu_hold = 1'b1;
            bus_oe   = 1'b1;
            bus_o    = DATA_W'(addr);
            mi       = 1'b1;
         end
         DATA: begin
            cpu_hold = 1'b1;
            bus_oe   = 1'b1;
            bus_o    = data_q;
            ri       = 1'b1;
         end
         RST_CPU: begin
            cpu_hold = 1'b1;
            cpu_rst  = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard: expected
// (address, byte) pairs are queued when the host hands a byte over and
// popped when the loader issues the RAM write strobe.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic [3:0] start_addr = '0;
   logic [4:0] load_len = '0;
   logic       abort = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       cpu_step_zero = 1'b0;
   logic       cpu_hold, cpu_rst, bus_oe, mi, ri, busy, done, aborted;
   logic [7:0] bus_o;
   logic [16:0] outs;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];

   int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
   int ri_cnt = 0, rst_cnt = 0, done_cnt = 0, abort_cnt = 0;
   logic [7:0] last_mi = '0;

   prog_loader #(.ADDR_W(4), .DATA_W(8), .RST_CYCLES(2)) dut (
      .clk           (clk),
      .clr           (clr),
      .start         (start),
      .start_addr    (start_addr),
      .load_len      (load_len),
      .abort         (abort),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cpu_step_zero (cpu_step_zero),
      .cpu_hold      (cpu_hold),
      .cpu_rst       (cpu_rst),
      .bus_o         (bus_o),
      .bus_oe        (bus_oe),
      .mi            (mi),
      .ri            (ri),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted)
   );

   assign outs = {in_ready, cpu_hold, cpu_rst, bus_o, bus_oe, mi, ri, busy, done, aborted};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (clr) begin
         if (mi) begin
            last_mi = bus_o;
            chk("mi_oe_no_ri", {30'd0, bus_oe, ri}, 32'd2);
         end
         if (ri) begin
            ri_cnt++;
            chk("ri_oe_no_mi", {30'd0, bus_oe, mi}, 32'd2);
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("ri_addr", {24'd0, last_mi}, {28'd0, e.a});
               chk("ri_data", {24'd0, bus_o}, {24'd0, e.d});
            end
         end
         if (!bus_oe) chk("bus_idle_zero", {24'd0, bus_o}, 32'd0);
         if (cpu_rst) rst_cnt++;
         if (done)    done_cnt++;
         if (aborted) abort_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] a, input logic [4:0] l);
      start_addr = a;
      load_len   = l;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      chk(tag, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [3:0] a);
      exp_t e;
      in_data  = d;
      in_valid = 1'b1;
      wait_ready("ready_seen");
      if (in_ready) begin
         e.a = a;
         e.d = d;
         sb.push_back(e);
         step();
      end
   endtask

   task automatic wait_done();
      int   n    = 0;
      logic prev = 1'b0;
      while (!done && n < 100) begin
         prev = cpu_rst;
         step();
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("rst_before_done", {31'd0, prev}, 32'd1);
      chk("done_hold_low", {31'd0, cpu_hold}, 32'd0);
      chk("done_rst_low", {31'd0, cpu_rst}, 32'd0);
      step();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_not_busy", {31'd0, busy}, 32'd0);
      chk("idle_hold_low", {31'd0, cpu_hold}, 32'd0);
   endtask

   initial begin
      int r0, d0, ri0, ab0;
      logic [3:0] a;

      // Power-on reset.
      #2 clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {15'd0, outs}, 32'd0);
      clr = 1'b1;
      step();
      chk("post_reset_outs", {15'd0, outs}, 32'd0);

      // 1: asynchronous reset while waiting for a byte.
      cpu_step_zero = 1'b1;
      do_start(4'd3, 5'd2);
      wait_ready("t1_in_wait_byte");
      chk("t1_hold_high", {31'd0, cpu_hold}, 32'd1);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("t1_async_clr", {15'd0, outs}, 32'd0);
      @(posedge clk);
      #1;
      chk("t1_clr_held", {15'd0, outs}, 32'd0);
      clr = 1'b1;
      step();
      chk("t1_idle", {31'd0, busy}, 32'd0);

      // 2: three bytes from address 0, in_valid kept high.
      r0 = rst_cnt;
      d0 = done_cnt;
      do_start(4'd0, 5'd3);
      send_byte(8'h1E, 4'd0);
      send_byte(8'h2F, 4'd1);
      send_byte(8'hE0, 4'd2);
      in_valid = 1'b0;
      wait_done();
      chk("t2_rst_cycles", 32'(rst_cnt - r0), 32'd2);
      chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // 3: wait for the instruction boundary.
      cpu_step_zero = 1'b0;
      do_start(4'd4, 5'd1);
      repeat (5) begin
         chk("t3_hold_low", {31'd0, cpu_hold}, 32'd0);
         chk("t3_no_drive", {29'd0, bus_oe, mi, ri}, 32'd0);
         chk("t3_busy", {31'd0, busy}, 32'd1);
         step();
      end
      cpu_step_zero = 1'b1;
      #1;
      chk("t3_hold_before_edge", {31'd0, cpu_hold}, 32'd0);
      step();
      chk("t3_hold_rise", {31'd0, cpu_hold}, 32'd1);
      send_byte(8'h5A, 4'd4);
      in_valid = 1'b0;
      wait_done();

      // 4: full 16-byte load from address 15 with a 3-cycle host gap.
      ri0 = ri_cnt;
      do_start(4'd15, 5'd0);
      for (int i = 0; i < 8; i++) begin
         a = 4'(15 + i);
         send_byte(8'(i * 7 + 3), a);
      end
      in_valid = 1'b0;
      step();
      step();
      repeat (3) begin
         chk("t4_gap_no_strobe", {30'd0, mi, ri}, 32'd0);
         chk("t4_gap_ready", {31'd0, in_ready}, 32'd1);
         step();
      end
      for (int i = 8; i < 16; i++) begin
         a = 4'(15 + i);
         send_byte(8'(i * 7 + 3), a);
      end
      in_valid = 1'b0;
      wait_done();
      chk("t4_ri_count", 32'(ri_cnt - ri0), 32'd16);

      // 5: abort together with a valid byte after one write.
      ab0 = abort_cnt;
      r0  = rst_cnt;
      ri0 = ri_cnt;
      do_start(4'd5, 5'd4);
      send_byte(8'h11, 4'd5);
      in_valid = 1'b0;
      wait_ready("t5_back_to_wait");
      in_data  = 8'h77;
      in_valid = 1'b1;
      abort    = 1'b1;
      #1;
      chk("t5_ready_forced_low", {31'd0, in_ready}, 32'd0);
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("t5_aborted_pulse", {31'd0, aborted}, 32'd1);
      chk("t5_not_busy", {31'd0, busy}, 32'd0);
      chk("t5_hold_low", {31'd0, cpu_hold}, 32'd0);
      chk("t5_no_rst", {31'd0, cpu_rst}, 32'd0);
      step();
      chk("t5_aborted_one_cycle", {31'd0, aborted}, 32'd0);
      chk("t5_abort_count", 32'(abort_cnt - ab0), 32'd1);
      chk("t5_rst_count", 32'(rst_cnt - r0), 32'd0);
      chk("t5_ri_count", 32'(ri_cnt - ri0), 32'd1);

      // 6: start during DATA is ignored; a later start is accepted.
      d0 = done_cnt;
      do_start(4'd2, 5'd2);
      send_byte(8'hA1, 4'd2);
      in_valid = 1'b0;
      step();
      chk("t6_in_data_phase", {31'd0, ri}, 32'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      send_byte(8'hB2, 4'd3);
      in_valid = 1'b0;
      wait_done();
      step();
      step();
      chk("t6_start_ignored", {31'd0, busy}, 32'd0);
      chk("t6_one_done", 32'(done_cnt - d0), 32'd1);
      do_start(4'd9, 5'd1);
      chk("t6_restart_busy", {31'd0, busy}, 32'd1);
      send_byte(8'hC3, 4'd9);
      in_valid = 1'b0;
      wait_done();
      chk("t6_two_done", 32'(done_cnt - d0), 32'd2);

      chk("sb_final_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
